// File: rtl/shift_pkg.sv
// Shared types and constants for the shift arbiter.
// Holds the datapath widths, the FSM state encoding and the requester ids.
package shift_pkg;

  localparam int unsigned WIDTH = 16;  // shifter data width, fixed
  localparam int unsigned MAG_W = 4;   // shift magnitude width, range 0..15

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StResp  = 2'b10
  } state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/shift_arbiter_if.sv
// Request/response bundle between the two requesters and the shift arbiter.
// Signals:
//   reqN_valid/reqN_ready/reqN_a/reqN_mag   request channel of requester N
//   rspN_valid/rspN_ready/rspN_q/rspN_ovf   response channel of requester N
// Modports: master = requester side, slave = arbiter side.
interface shift_arbiter_if;
  import shift_pkg::*;

  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [MAG_W-1:0] req0_mag;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [MAG_W-1:0] req1_mag;

  logic             rsp0_valid;
  logic             rsp0_ready;
  logic [WIDTH-1:0] rsp0_q;
  logic             rsp0_ovf;
  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [WIDTH-1:0] rsp1_q;
  logic             rsp1_ovf;

  modport master (
    output req0_valid, req0_a, req0_mag, req1_valid, req1_a, req1_mag,
    output rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_q, rsp0_ovf, rsp1_valid, rsp1_q, rsp1_ovf
  );

  modport slave (
    input  req0_valid, req0_a, req0_mag, req1_valid, req1_a, req1_mag,
    input  rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_q, rsp0_ovf, rsp1_valid, rsp1_q, rsp1_ovf
  );

endinterface

// File: rtl/leftshifter16bit.sv
// Combinational 16-bit logical left shifter, zero fill.
// Ports:
//   a    in  16  operand
//   mag  in  4   shift amount 0..15
//   q    out 16  a << mag, bits past bit 15 discarded
module leftshifter16bit (
  input  logic [15:0] a,
  input  logic [3:0]  mag,
  output logic [15:0] q
);

  logic [15:0] s1;
  logic [15:0] s2;
  logic [15:0] s4;

  // Log-stage barrel: each stage shifts by one power of two.
  always_comb begin
    s1 = mag[0] ? {a[14:0], 1'b0}  : a;
    s2 = mag[1] ? {s1[13:0], 2'b0} : s1;
    s4 = mag[2] ? {s2[11:0], 4'b0} : s2;
    q  = mag[3] ? {s4[7:0], 8'b0}  : s4;
  end

endmodule

// File: rtl/shift_arbiter.sv
// Shares one 16-bit left shifter between two requesters with round-robin arbitration.
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   bus    slave side of shift_arbiter_if (request and response channels of both requesters)
//   busy   out  high whenever the FSM is not idle
// One operation at a time: accept in IDLE, shift in SHIFT, hold the result in RESP until the
// owner takes it. Priority moves to the other requester after each completed response.
module shift_arbiter
  import shift_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  shift_arbiter_if.slave  bus,
  output logic            busy
);

  localparam logic [WIDTH-1:0] AllOnes = '1;

  state_e           state_q, state_d;
  logic             rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [MAG_W-1:0] mag_q, mag_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             ovf_q, ovf_d;
  logic             owner_q, owner_d;

  logic             any_valid;
  logic             grant;
  logic             owner_rsp_ready;
  logic [WIDTH-1:0] shift_q;

  leftshifter16bit u_shifter (
    .a   (a_q),
    .mag (mag_q),
    .q   (shift_q)
  );

  // A lone requester always wins; rr_ptr only breaks ties.
  assign any_valid       = bus.req0_valid | bus.req1_valid;
  assign grant           = (bus.req0_valid && bus.req1_valid) ? rr_ptr_q : bus.req1_valid;
  assign owner_rsp_ready = (owner_q == REQ1) ? bus.rsp1_ready : bus.rsp0_ready;

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    a_d            = a_q;
    mag_d          = mag_q;
    q_d            = q_q;
    ovf_d          = ovf_q;
    owner_d        = owner_q;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.rsp0_valid = 1'b0;
    bus.rsp1_valid = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (any_valid) begin
          bus.req0_ready = (grant == REQ0);
          bus.req1_ready = (grant == REQ1);
          a_d            = (grant == REQ1) ? bus.req1_a : bus.req0_a;
          mag_d          = (grant == REQ1) ? bus.req1_mag : bus.req0_mag;
          owner_d        = grant;
          state_d        = StShift;
        end
      end
      StShift: begin
        q_d     = shift_q;
        // Overflow iff any of the top mag bits of the operand is set.
        ovf_d   = |(a_q & ~(AllOnes >> mag_q));
        state_d = StResp;
      end
      StResp: begin
        bus.rsp0_valid = (owner_q == REQ0);
        bus.rsp1_valid = (owner_q == REQ1);
        if (owner_rsp_ready) begin
          rr_ptr_d = ~owner_q;
          state_d  = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      rr_ptr_q <= REQ0;
      a_q      <= '0;
      mag_q    <= '0;
      q_q      <= '0;
      ovf_q    <= 1'b0;
      owner_q  <= REQ0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      a_q      <= a_d;
      mag_q    <= mag_d;
      q_q      <= q_d;
      ovf_q    <= ovf_d;
      owner_q  <= owner_d;
    end
  end

  assign bus.rsp0_q   = q_q;
  assign bus.rsp1_q   = q_q;
  assign bus.rsp0_ovf = ovf_q;
  assign bus.rsp1_ovf = ovf_q;
  assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: vector table, hand-written corner sequences and a
// randomized run against a transaction-level reference model.
module tb_shift_arbiter;
  import shift_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;

  shift_arbiter_if sif ();

  shift_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit          id;
    logic [15:0] a;
    logic [3:0]  mag;
    logic [15:0] q;
    bit          ovf;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_req(input bit id, input bit v, input logic [15:0] a, input logic [3:0] m);
    if (id) begin
      sif.req1_valid = v; sif.req1_a = a; sif.req1_mag = m;
    end else begin
      sif.req0_valid = v; sif.req0_a = a; sif.req0_mag = m;
    end
  endtask

  task automatic set_rsp_ready(input bit id, input bit v);
    if (id) sif.rsp1_ready = v;
    else    sif.rsp0_ready = v;
  endtask

  function automatic logic get_ready(input bit id);
    return id ? sif.req1_ready : sif.req0_ready;
  endfunction

  function automatic logic get_rsp_valid(input bit id);
    return id ? sif.rsp1_valid : sif.rsp0_valid;
  endfunction

  function automatic logic [15:0] get_q(input bit id);
    return id ? sif.rsp1_q : sif.rsp0_q;
  endfunction

  function automatic logic get_ovf(input bit id);
    return id ? sif.rsp1_ovf : sif.rsp0_ovf;
  endfunction

  // Reference arithmetic: widen, shift, split into kept and lost halves.
  function automatic logic [15:0] ref_q(input logic [15:0] a, input logic [3:0] m);
    logic [31:0] w;
    w = {16'b0, a} << m;
    return w[15:0];
  endfunction

  function automatic logic ref_ovf(input logic [15:0] a, input logic [3:0] m);
    logic [31:0] w;
    w = {16'b0, a} << m;
    return w[31:16] != 16'b0;
  endfunction

  task automatic clear_inputs();
    drive_req(1'b0, 1'b0, 16'h0, 4'h0);
    drive_req(1'b1, 1'b0, 16'h0, 4'h0);
    sif.rsp0_ready = 1'b0;
    sif.rsp1_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Lone request, accepted immediately, result two cycles later, taken on first RESP cycle.
  task automatic run_op(input bit id, input logic [15:0] a, input logic [3:0] m,
                        input logic [15:0] q, input bit ovf);
    @(negedge clk);
    drive_req(id, 1'b1, a, m);
    #1;
    chk("op_grant", get_ready(id), 1'b1);
    chk("op_busy_idle", busy, 1'b0);
    @(negedge clk);
    drive_req(id, 1'b0, 16'h0, 4'h0);
    #1;
    chk("op_shift_busy", busy, 1'b1);
    chk("op_shift_rsp_valid", get_rsp_valid(id), 1'b0);
    @(negedge clk);
    #1;
    chk("op_rsp_valid", get_rsp_valid(id), 1'b1);
    chk("op_rsp_other_valid", get_rsp_valid(!id), 1'b0);
    chk("op_rsp_q", get_q(id), q);
    chk("op_rsp_ovf", get_ovf(id), ovf);
    set_rsp_ready(id, 1'b1);
    @(negedge clk);
    set_rsp_ready(id, 1'b0);
    #1;
    chk("op_done_busy", busy, 1'b0);
  endtask

  initial begin
    logic [15:0] exp_q;
    bit          v0, v1, r0, r1;
    logic [15:0] a0, a1;
    logic [3:0]  m0, m1;
    bit          outstanding, own, prio, rv, exp_r0, exp_r1;
    int          cnt;
    logic [15:0] mq;
    bit          movf;

    vecs[0] = '{1'b0, 16'h0001, 4'h4, 16'h0010, 1'b0};
    vecs[1] = '{1'b1, 16'h1111, 4'hF, 16'h8000, 1'b1};
    vecs[2] = '{1'b1, 16'h0101, 4'h5, 16'h2020, 1'b0};
    vecs[3] = '{1'b1, 16'hFFFF, 4'h0, 16'hFFFF, 1'b0};
    vecs[4] = '{1'b0, 16'h00FF, 4'h8, 16'hFF00, 1'b0};
    vecs[5] = '{1'b0, 16'h8001, 4'h1, 16'h0002, 1'b1};
    vecs[6] = '{1'b1, 16'hABCD, 4'h4, 16'hBCD0, 1'b1};

    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_req0_ready", sif.req0_ready, 1'b0);
    chk("rst_req1_ready", sif.req1_ready, 1'b0);
    chk("rst_rsp0_valid", sif.rsp0_valid, 1'b0);
    chk("rst_rsp1_valid", sif.rsp1_valid, 1'b0);
    chk("rst_q", sif.rsp0_q, 16'h0);
    chk("rst_ovf", sif.rsp0_ovf, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_op(vecs[i].id, vecs[i].a, vecs[i].mag, vecs[i].q, vecs[i].ovf);

    // Contention right after reset: req0 first, req1 held and served next, then req0 again.
    do_reset();
    @(negedge clk);
    drive_req(1'b0, 1'b1, 16'h0003, 4'h1);
    drive_req(1'b1, 1'b1, 16'h0005, 4'h2);
    #1;
    chk("cont_ready0", sif.req0_ready, 1'b1);
    chk("cont_ready1_blocked", sif.req1_ready, 1'b0);
    @(negedge clk);
    drive_req(1'b0, 1'b0, 16'h0, 4'h0);
    #1;
    chk("cont_shift_ready1", sif.req1_ready, 1'b0);
    @(negedge clk);
    #1;
    chk("cont_rsp0_valid", sif.rsp0_valid, 1'b1);
    chk("cont_rsp0_q", sif.rsp0_q, 16'h0006);
    chk("cont_resp_ready1", sif.req1_ready, 1'b0);
    sif.rsp0_ready = 1'b1;
    @(negedge clk);
    sif.rsp0_ready = 1'b0;
    #1;
    chk("cont_ready1_granted", sif.req1_ready, 1'b1);
    chk("cont_ready0_idle", sif.req0_ready, 1'b0);
    @(negedge clk);
    drive_req(1'b1, 1'b0, 16'h0, 4'h0);
    @(negedge clk);
    #1;
    chk("cont_rsp1_valid", sif.rsp1_valid, 1'b1);
    chk("cont_rsp1_q", sif.rsp1_q, 16'h0014);
    sif.rsp1_ready = 1'b1;
    @(negedge clk);
    sif.rsp1_ready = 1'b0;
    drive_req(1'b0, 1'b1, 16'h0007, 4'h0);
    drive_req(1'b1, 1'b1, 16'h0009, 4'h0);
    #1;
    chk("cont2_ready0", sif.req0_ready, 1'b1);
    chk("cont2_ready1", sif.req1_ready, 1'b0);
    @(negedge clk);
    clear_inputs();
    @(negedge clk);
    sif.rsp0_ready = 1'b1;
    @(negedge clk);
    sif.rsp0_ready = 1'b0;

    // Backpressure: priority now on req1, but a lone req0 still wins. Result held 5 cycles,
    // req1 waits, and a stray rsp1_ready while rsp1_valid is low has no effect.
    drive_req(1'b0, 1'b1, 16'h0123, 4'h4);
    #1;
    chk("bp_lone_grant0", sif.req0_ready, 1'b1);
    @(negedge clk);
    drive_req(1'b0, 1'b0, 16'h0, 4'h0);
    drive_req(1'b1, 1'b1, 16'h0F0F, 4'h3);
    sif.rsp1_ready = 1'b1;
    #1;
    chk("bp_shift_ready1", sif.req1_ready, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_rsp0_valid", sif.rsp0_valid, 1'b1);
      chk("bp_rsp0_q", sif.rsp0_q, 16'h1230);
      chk("bp_ready1", sif.req1_ready, 1'b0);
      @(negedge clk);
    end
    #1;
    chk("bp_rsp0_still", sif.rsp0_valid, 1'b1);
    sif.rsp0_ready = 1'b1;
    @(negedge clk);
    sif.rsp0_ready = 1'b0;
    #1;
    chk("bp_release_ready1", sif.req1_ready, 1'b1);
    @(negedge clk);
    drive_req(1'b1, 1'b0, 16'h0, 4'h0);
    @(negedge clk);
    #1;
    chk("bp_rsp1_valid", sif.rsp1_valid, 1'b1);
    chk("bp_rsp1_q", sif.rsp1_q, 16'h7878);
    chk("bp_rsp1_ovf", sif.rsp1_ovf, 1'b0);
    @(negedge clk);
    sif.rsp1_ready = 1'b0;
    #1;
    chk("bp_early_ready_done", busy, 1'b0);

    // Reset during SHIFT discards the operation.
    @(negedge clk);
    drive_req(1'b0, 1'b1, 16'h00FF, 4'h8);
    #1;
    chk("rm_grant", sif.req0_ready, 1'b1);
    @(negedge clk);
    drive_req(1'b0, 1'b0, 16'h0, 4'h0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rm_busy", busy, 1'b0);
    chk("rm_rsp0_valid", sif.rsp0_valid, 1'b0);
    chk("rm_q", sif.rsp0_q, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("rm_no_rsp", sif.rsp0_valid, 1'b0);
      chk("rm_idle", busy, 1'b0);
    end
    run_op(1'b0, 16'h00FF, 4'h8, 16'hFF00, 1'b0);

    // Sweep: back-to-back from req0 with rsp0_ready tied high, one result per 3 cycles.
    @(negedge clk);
    sif.rsp0_ready = 1'b1;
    for (int m = 0; m < 16; m++) begin
      drive_req(1'b0, 1'b1, 16'h0001, 4'(m));
      #1;
      chk("sw_grant", sif.req0_ready, 1'b1);
      @(negedge clk);
      #1;
      chk("sw_shift_noready", sif.req0_ready, 1'b0);
      @(negedge clk);
      #1;
      exp_q = 16'h0001 << m;
      chk("sw_rsp_valid", sif.rsp0_valid, 1'b1);
      chk("sw_q", sif.rsp0_q, exp_q);
      chk("sw_ovf", sif.rsp0_ovf, 1'b0);
      @(negedge clk);
    end
    clear_inputs();

    // Randomized run against a transaction-level model.
    do_reset();
    outstanding = 0; own = 0; prio = 0; cnt = 0; mq = '0; movf = 0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      v0 = ($urandom_range(0, 2) != 0);
      v1 = ($urandom_range(0, 2) != 0);
      a0 = 16'($urandom);
      a1 = 16'($urandom);
      m0 = 4'($urandom_range(0, 15));
      m1 = 4'($urandom_range(0, 15));
      r0 = ($urandom_range(0, 1) != 0);
      r1 = ($urandom_range(0, 1) != 0);
      drive_req(1'b0, v0, a0, m0);
      drive_req(1'b1, v1, a1, m1);
      sif.rsp0_ready = r0;
      sif.rsp1_ready = r1;
      #1;
      exp_r0 = !outstanding && v0 && (!v1 || prio == 1'b0);
      exp_r1 = !outstanding && v1 && (!v0 || prio == 1'b1);
      rv     = outstanding && (cnt >= 2);
      chk("rnd_ready0", sif.req0_ready, exp_r0);
      chk("rnd_ready1", sif.req1_ready, exp_r1);
      chk("rnd_busy", busy, outstanding);
      chk("rnd_rsp0_valid", sif.rsp0_valid, rv && !own);
      chk("rnd_rsp1_valid", sif.rsp1_valid, rv && own);
      if (rv) begin
        chk("rnd_q", get_q(own), mq);
        chk("rnd_ovf", get_ovf(own), movf);
      end
      if (!outstanding) begin
        if (exp_r0 || exp_r1) begin
          outstanding = 1;
          own  = exp_r1;
          mq   = exp_r1 ? ref_q(a1, m1) : ref_q(a0, m0);
          movf = exp_r1 ? ref_ovf(a1, m1) : ref_ovf(a0, m0);
          cnt  = 1;
        end
      end else if (rv && (own ? r1 : r0)) begin
        outstanding = 0;
        prio = !own;
      end else begin
        cnt++;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
